// File: rtl/hd_err_channel.sv
// +----------------------------------------------------------------------------+
// | hd_err_channel : registered Hamming-codeword channel that flips 1-2 bits   |
// |   on a programmable word cadence using LFSR-chosen positions.              |
// | Optional: define HD_ERR_MASK_OUT_EN to add the err_mask output.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hd_err_channel #(
  parameter int          K    = 7,
  parameter int          M    = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [K+M-1:0]   cin,
  input  logic             cvld,
  input  logic [1:0]       mode,
  input  logic [7:0]       err_period,
  input  logic             cnt_clr,
  output logic [K+M-1:0]   cout,
  output logic             covld,
  output logic [15:0]      word_cnt,
  output logic [15:0]      err_cnt
`ifdef HD_ERR_MASK_OUT_EN
  ,
  output logic [K+M-1:0]   err_mask
`endif
);

  localparam int             N       = K + M;
  localparam logic [7:0]     N_W     = 8'(N);
  localparam logic [N-1:0]   ONE_HOT = N'(1);

  logic [N-1:0] cout_q, cout_d;
  logic         covld_q, covld_d;
  logic [15:0]  word_q, word_d;
  logic [15:0]  err_q, err_d;
  logic [7:0]   pcnt_q, pcnt_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic         alt_q, alt_d;
  logic [N-1:0] mask_q, mask_d;

  logic [7:0]   w_p1, w_p2_raw, w_p1_inc, w_p2;
  logic         w_wrap, w_inj, w_double, w_fb;
  logic [N-1:0] w_mask;

  // Positions come from the LFSR value before it steps for this word.
  always_comb begin
    w_p1     = lfsr_q[7:0] % N_W;
    w_p2_raw = lfsr_q[15:8] % N_W;
    w_p1_inc = (w_p1 == N_W - 8'd1) ? 8'd0 : w_p1 + 8'd1;
    w_p2     = (w_p2_raw == w_p1) ? w_p1_inc : w_p2_raw;
    w_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    w_wrap   = (pcnt_q == err_period - 8'd1);
    w_inj    = (err_period != 8'd0) && w_wrap && (mode != 2'd0);
    w_double = (mode == 2'd2) || ((mode == 2'd3) && alt_q);
    w_mask   = '0;
    if (w_inj) begin
      w_mask = (ONE_HOT << w_p1) | (w_double ? (ONE_HOT << w_p2) : '0);
    end
  end

  always_comb begin
    cout_d  = cout_q;
    covld_d = cvld;
    word_d  = word_q;
    err_d   = err_q;
    pcnt_d  = pcnt_q;
    lfsr_d  = lfsr_q;
    alt_d   = alt_q;
    mask_d  = mask_q;
    if (cvld) begin
      cout_d = cin ^ w_mask;
      mask_d = w_mask;
      lfsr_d = {lfsr_q[14:0], w_fb};
      // The single/double alternation only advances on mode-3 injections.
      if (w_inj && (mode == 2'd3)) begin
        alt_d = ~alt_q;
      end
    end
    if (cnt_clr) begin
      word_d = '0;
      err_d  = '0;
      pcnt_d = '0;
    end else if (cvld) begin
      if (word_q != 16'hFFFF) word_d = word_q + 16'd1;
      if (w_inj && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      pcnt_d = ((err_period == 8'd0) || w_wrap) ? 8'd0 : pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_q  <= '0;
      covld_q <= 1'b0;
      word_q  <= '0;
      err_q   <= '0;
      pcnt_q  <= '0;
      lfsr_q  <= SEED;
      alt_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      cout_q  <= cout_d;
      covld_q <= covld_d;
      word_q  <= word_d;
      err_q   <= err_d;
      pcnt_q  <= pcnt_d;
      lfsr_q  <= lfsr_d;
      alt_q   <= alt_d;
      mask_q  <= mask_d;
    end
  end

  assign cout     = cout_q;
  assign covld    = covld_q;
  assign word_cnt = word_q;
  assign err_cnt  = err_q;

`ifdef HD_ERR_MASK_OUT_EN
  assign err_mask = mask_q;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^mask_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hd_err_channel.sv
// +----------------------------------------------------------------------------+
// | tb_hd_err_channel : randomized bench for hd_err_channel with a reference   |
// |   channel model and literal anchors. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hd_err_channel;

  localparam int N = 11;

  logic          clk;
  logic          rst;
  logic [N-1:0]  cin;
  logic          cvld;
  logic [1:0]    mode;
  logic [7:0]    err_period;
  logic          cnt_clr;
  logic [N-1:0]  cout;
  logic          covld;
  logic [15:0]   word_cnt;
  logic [15:0]   err_cnt;
`ifdef HD_ERR_MASK_OUT_EN
  logic [N-1:0]  err_mask;
`endif

  hd_err_channel #(.K(7), .M(4), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cin        (cin),
    .cvld       (cvld),
    .mode       (mode),
    .err_period (err_period),
    .cnt_clr    (cnt_clr),
    .cout       (cout),
    .covld      (covld),
    .word_cnt   (word_cnt),
    .err_cnt    (err_cnt)
`ifdef HD_ERR_MASK_OUT_EN
    ,
    .err_mask   (err_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int collisions = 0;

  // Reference channel state
  bit [15:0]    m_lfsr;
  int           m_since;   // words since the last cadence wrap
  bit           m_alt;
  int           m_word;
  int           m_err;
  logic [N-1:0] m_cout;
  logic [N-1:0] m_mask;
  bit           m_covld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_since = 0;
    m_alt   = 1'b0;
    m_word  = 0;
    m_err   = 0;
    m_cout  = '0;
    m_mask  = '0;
    m_covld = 1'b0;
  endtask

  task automatic model_edge();
    int p1, p2, per;
    bit inj, dbl;
    logic [N-1:0] mask;
    if (rst) begin
      model_reset();
      return;
    end
    m_covld = cvld;
    if (cvld) begin
      per = int'(err_period);
      p1  = int'(m_lfsr[7:0]) % N;
      p2  = int'(m_lfsr[15:8]) % N;
      inj = (per != 0) && (m_since == per - 1) && (mode != 2'd0);
      dbl = (mode == 2'd2) || (mode == 2'd3 && m_alt);
      if (p2 == p1) begin
        p2 = (p1 + 1) % N;
        if (inj && dbl) collisions++;
      end
      mask = '0;
      if (inj) begin
        mask[p1] = 1'b1;
        if (dbl) mask[p2] = 1'b1;
        if (mode == 2'd3) m_alt = !m_alt;
      end
      m_cout = cin ^ mask;
      m_mask = mask;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (!cnt_clr) begin
        if (m_word < 65535) m_word++;
        if (inj && m_err < 65535) m_err++;
        if (per == 0 || m_since == per - 1) m_since = 0;
        else m_since = (m_since + 1) % 256;
      end
    end
    if (cnt_clr) begin
      m_word  = 0;
      m_err   = 0;
      m_since = 0;
    end
  endtask

  task automatic compare();
    check("covld", 32'(covld), 32'(m_covld));
    check("cout", 32'(cout), 32'(m_cout));
    check("word_cnt", 32'(word_cnt), 32'(m_word));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
`ifdef HD_ERR_MASK_OUT_EN
    check("err_mask", 32'(err_mask), 32'(m_mask));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [N-1:0] c, input logic v, input logic [1:0] md,
                       input logic [7:0] per, input logic clr);
    cin        = c;
    cvld       = v;
    mode       = md;
    err_period = per;
    cnt_clr    = clr;
  endtask

  logic [N-1:0] sent;
  int           coll_base;

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, 2'd0, 8'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_covld", 32'(covld), 32'h0);
    check("rst_word", 32'(word_cnt), 32'h0);
    rst = 1'b0;

    // Pass-through of a single word
    drive(11'h5A3, 1'b1, 2'd0, 8'd1, 1'b0);
    step();
    check("t1_covld", 32'(covld), 32'h1);
    check("t1_cout", 32'(cout), 32'h5A3);
    check("t1_word", 32'(word_cnt), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);

    // Single flips on every word
    drive('0, 1'b0, 2'd0, 8'd1, 1'b1);
    step();
    for (int i = 0; i < 20; i++) begin
      sent = N'($urandom);
      drive(sent, 1'b1, 2'd1, 8'd1, 1'b0);
      step();
      check("t2_popcount", 32'($countones(cout ^ sent)), 32'd1);
    end
    check("t2_err", 32'(err_cnt), 32'd20);

    // Double flips every third word
    drive('0, 1'b0, 2'd2, 8'd3, 1'b1);
    step();
    for (int i = 0; i < 9; i++) begin
      sent = N'($urandom);
      drive(sent, 1'b1, 2'd2, 8'd3, 1'b0);
      step();
      check("t3_popcount", 32'($countones(cout ^ sent)), (i % 3 == 2) ? 32'd2 : 32'd0);
    end
    check("t3_err", 32'(err_cnt), 32'd3);
    check("t3_word", 32'(word_cnt), 32'd9);

    // Cadence disabled
    drive('0, 1'b0, 2'd0, 8'd0, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      sent = N'($urandom);
      drive(sent, 1'b1, 2'($urandom), 8'd0, 1'b0);
      step();
      check("t4_cout", 32'(cout), 32'(sent));
    end
    check("t4_err", 32'(err_cnt), 32'd0);
    check("t4_word", 32'(word_cnt), 32'd10);

    // Reset during an in-flight word, then SEED-derived positions
    drive(11'h7FF, 1'b1, 2'd1, 8'd1, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    step();
    check("t5_covld", 32'(covld), 32'h0);
    check("t5_word", 32'(word_cnt), 32'h0);
    check("t5_err", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    drive('0, 1'b1, 2'd1, 8'd1, 1'b0);
    step();
    check("t5_seed_p1", 32'(cout), 32'h020);
    rst = 1'b1;
    drive('0, 1'b0, 2'd2, 8'd1, 1'b0);
    step();
    rst = 1'b0;
    drive('0, 1'b1, 2'd2, 8'd1, 1'b0);
    step();
    check("t5_seed_p1p2", 32'(cout), 32'h0A0);

    // Long double-flip run to hit p1==p2 positions
    coll_base = collisions;
    for (int i = 0; i < 200; i++) begin
      sent = N'($urandom);
      drive(sent, 1'b1, 2'd2, 8'd1, 1'b0);
      step();
      check("t3_dbl_popcount", 32'($countones(cout ^ sent)), 32'd2);
    end
    check("t3_collision_seen", 32'(collisions > coll_base), 32'd1);

    // Randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] per;
      logic       v;
      case ($urandom_range(0, 4))
        0: per = 8'd0;
        1: per = 8'd1;
        2: per = 8'd2;
        3: per = 8'd3;
        default: per = 8'd5;
      endcase
      if ((i % 40) != 0) per = err_period;
      v = 1'($urandom);
      drive(v ? N'($urandom) : 'x, v, 2'($urandom), per, ($urandom_range(0, 19) == 0));
      step();
    end

    // Counter saturation, then clear with a concurrent word
    drive('0, 1'b0, 2'd3, 8'd1, 1'b1);
    step();
    for (int i = 0; i < 65534 + 3; i++) begin
      drive(N'(i), 1'b1, 2'd3, 8'd1, 1'b0);
      step();
    end
    check("t6_word_sat", 32'(word_cnt), 32'hFFFF);
    check("t6_err_sat", 32'(err_cnt), 32'hFFFF);
    drive(11'h123, 1'b1, 2'd0, 8'd1, 1'b1);
    step();
    check("t6_clr_word", 32'(word_cnt), 32'h0);
    check("t6_clr_covld", 32'(covld), 32'h1);
    check("t6_clr_cout", 32'(cout), 32'h123);
    drive('0, 1'b0, 2'd0, 8'd1, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
